// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART: configurable data width, parity and stop bits,
// 16x-oversampled receiver with majority vote and parity/framing/overrun reporting.
module uart_cfg #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned DIV      = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned BIT_CLKS = OVERSAMPLE * DIV;
    localparam int unsigned CW       = $clog2(BIT_CLKS + 1);
    localparam int unsigned DW       = $clog2(DIV + 1);
    localparam int unsigned TW       = $clog2(OVERSAMPLE);
    localparam int unsigned BW       = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF     = OVERSAMPLE / 2;

    generate
        if (DIV < 1) begin : g_div_chk
            $error("uart_cfg: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
        end
    endgenerate

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t            r_tx_state;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic                 r_tx_busy;
    logic [CW-1:0]        r_tx_cnt;
    logic [BW-1:0]        r_tx_bit;
    logic                 r_tx_stop;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == CW'(BIT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            if (r_tx_state != TX_IDLE)
                r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + CW'(1);
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_valid && r_tx_ready) begin
                        r_tx_shift <= tx_data;
                        r_tx_par   <= (PARITY == 2) ? ^tx_data : ~^tx_data;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_ready <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                        r_tx_bit   <= '0;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_bit == BW'(DATA_BITS - 1)) begin
                            r_tx_stop <= 1'b0;
                            if (PARITY != 0) begin
                                r_tx_state <= TX_PAR;
                                r_tx       <= r_tx_par;
                            end else begin
                                r_tx_state <= TX_STOP;
                                r_tx       <= 1'b1;
                            end
                        end else begin
                            r_tx_bit   <= r_tx_bit + BW'(1);
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end
                end
                TX_PAR: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= TX_STOP;
                        r_tx       <= 1'b1;
                        r_tx_stop  <= 1'b0;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_stop == 1'(STOP_BITS - 1)) begin
                            r_tx_state <= TX_IDLE;
                            r_tx_ready <= 1'b1;
                            r_tx_busy  <= 1'b0;
                        end else begin
                            r_tx_stop <= 1'b1;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign tx_busy  = r_tx_busy;

    // ---------------- receiver ----------------
    rx_state_t            r_rx_state;
    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    logic [DW-1:0]        r_rx_div;
    logic [TW-1:0]        r_rx_tick;
    logic [1:0]           r_rx_ones;
    logic [BW-1:0]        r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_rx_s, w_tick, w_samp, w_decide, w_bit_end, w_vote, w_consume, w_par_ok;

    assign w_rx_s    = r_sync[1];
    assign w_tick    = (r_rx_div == DW'(DIV - 1));
    assign w_samp    = w_tick && ((r_rx_tick == TW'(HALF - 1)) || (r_rx_tick == TW'(HALF)) ||
                                  (r_rx_tick == TW'(HALF + 1)));
    assign w_decide  = w_tick && (r_rx_tick == TW'(HALF + 1));
    assign w_bit_end = w_tick && (r_rx_tick == TW'(OVERSAMPLE - 1));
    // Third vote sample is the live one; the first two are accumulated in r_rx_ones.
    assign w_vote    = ((r_rx_ones + 2'(w_rx_s)) >= 2'd2);
    assign w_consume = r_rx_valid && rx_ready;
    assign w_par_ok  = (PARITY == 2) ? ((^r_rx_shift) == r_rx_par) : ((~^r_rx_shift) == r_rx_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= 2'b11;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_div     <= '0;
            r_rx_tick    <= '0;
            r_rx_ones    <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par     <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], rx};
            r_rx_prev    <= w_rx_s;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            if (w_consume)
                r_rx_valid <= 1'b0;
            if (r_rx_state != RX_IDLE) begin
                r_rx_div <= w_tick ? '0 : r_rx_div + DW'(1);
                if (w_tick)
                    r_rx_tick <= (r_rx_tick == TW'(OVERSAMPLE - 1)) ? '0 : r_rx_tick + TW'(1);
                if (w_samp)
                    r_rx_ones <= w_decide ? '0 : r_rx_ones + 2'(w_rx_s);
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_rx_state <= RX_START;
                        r_rx_div   <= '0;
                        r_rx_tick  <= '0;
                        r_rx_ones  <= '0;
                        r_rx_bit   <= '0;
                    end
                end
                RX_START: begin
                    if (w_decide && w_vote)
                        r_rx_state <= RX_IDLE;
                    else if (w_bit_end)
                        r_rx_state <= RX_DATA;
                end
                RX_DATA: begin
                    if (w_decide) begin
                        r_rx_shift <= {w_vote, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + BW'(1);
                    end
                    if (w_bit_end && (r_rx_bit == BW'(DATA_BITS)))
                        r_rx_state <= (PARITY != 0) ? RX_PAR : RX_STOP;
                end
                RX_PAR: begin
                    if (w_decide)
                        r_rx_par <= w_vote;
                    if (w_bit_end)
                        r_rx_state <= RX_STOP;
                end
                RX_STOP: begin
                    // Decide at mid-stop so the next start edge is seen with half a bit of margin.
                    if (w_decide) begin
                        r_rx_state   <= RX_IDLE;
                        r_frame_err  <= ~w_vote;
                        r_parity_err <= (PARITY != 0) && !w_par_ok;
                        if (!r_rx_valid || w_consume) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: a default 8N1 instance at 432 clk/bit and a fast
// 7E1 instance (16 clk/bit) used for parity and loopback.
module tb_uart_cfg;

    localparam int B0 = 432;
    localparam int B1 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rx0, tx0, tx_valid0, tx_ready0, tx_busy0, rx_valid0, rx_ready0, pe0, fe0, ov0;
    logic [7:0] tx_data0, rx_data0;

    logic       rx1, rx1_drv, loop1, tx1, tx_valid1, tx_ready1, tx_busy1, rx_valid1, rx_ready1;
    logic       pe1, fe1, ov1;
    logic [6:0] tx_data1, rx_data1;

    assign rx1 = loop1 ? tx1 : rx1_drv;

    uart_cfg u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .tx(tx0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_busy(tx_busy0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0)
    );

    uart_cfg #(.CLK_FREQ(1_843_200), .DATA_BITS(7), .PARITY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .tx(tx1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_busy(tx_busy1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1)
    );

    int n_pe0 = 0, n_fe0 = 0, n_ov0 = 0, n_pe1 = 0, n_fe1 = 0, n_ov1 = 0;
    always @(posedge clk) begin
        if (pe0) n_pe0++;
        if (fe0) n_fe0++;
        if (ov0) n_ov0++;
        if (pe1) n_pe1++;
        if (fe1) n_fe1++;
        if (ov1) n_ov1++;
    end

    int errors = 0;
    int checks = 0;
    int b_pe, b_fe, b_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap0();
        b_pe = n_pe0; b_fe = n_fe0; b_ov = n_ov0;
    endtask

    task automatic snap1();
        b_pe = n_pe1; b_fe = n_fe1; b_ov = n_ov1;
    endtask

    // Drive n frame bits LSB first onto rx of instance `which`, each held bclk clocks.
    task automatic drive_rx(input int which, input logic [15:0] bits, input int n, input int bclk);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx0 = bits[i]; else rx1_drv = bits[i];
            repeat (bclk) @(negedge clk);
        end
        if (which == 0) rx0 = 1'b1; else rx1_drv = 1'b1;
    endtask

    task automatic consume0();
        rx_ready0 = 1'b1;
        @(negedge clk);
        rx_ready0 = 1'b0;
    endtask

    task automatic consume1();
        rx_ready1 = 1'b1;
        @(negedge clk);
        rx_ready1 = 1'b0;
    endtask

    // Send one 8N1 frame from instance 0 and check every bit mid-period and the ready timing.
    task automatic tx_frame0(input logic [7:0] d, input string tag);
        logic [9:0] f;
        int k;
        f = {1'b1, d, 1'b0};
        k = 0;
        while (!tx_ready0 && k < 10000) begin
            @(negedge clk);
            k++;
        end
        tx_data0  = d;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        chk({tag, "_acc_tx"}, 32'(tx0), 32'(0));
        chk({tag, "_acc_ready"}, 32'(tx_ready0), 32'(0));
        chk({tag, "_acc_busy"}, 32'(tx_busy0), 32'(1));
        repeat (B0 / 2) @(negedge clk);
        chk({tag, "_b0"}, 32'(tx0), 32'(f[0]));
        for (int i = 1; i < 10; i++) begin
            repeat (B0) @(negedge clk);
            chk($sformatf("%s_b%0d", tag, i), 32'(tx0), 32'(f[i]));
        end
        repeat (B0 / 2 - 1) @(negedge clk);
        chk({tag, "_ready_early"}, 32'(tx_ready0), 32'(0));
        @(negedge clk);
        chk({tag, "_ready_at_10bits"}, 32'(tx_ready0), 32'(1));
        chk({tag, "_busy_end"}, 32'(tx_busy0), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rx0 = 1'b1; rx1_drv = 1'b1; loop1 = 1'b0;
        tx_valid0 = 1'b0; tx_data0 = '0; rx_ready0 = 1'b0;
        tx_valid1 = 1'b0; tx_data1 = '0; rx_ready1 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx0), 32'(1));
        chk("rst_tx_ready", 32'(tx_ready0), 32'(1));
        chk("rst_tx_busy", 32'(tx_busy0), 32'(0));
        chk("rst_rx_valid", 32'(rx_valid0), 32'(0));
        chk("rst_rx_data", 32'(rx_data0), 32'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 receive of 0x5A, held until consumed
        snap0();
        drive_rx(0, 16'({1'b1, 8'h5A, 1'b0}), 10, B0);
        chk("rx5a_valid", 32'(rx_valid0), 32'(1));
        chk("rx5a_data", 32'(rx_data0), 32'h5A);
        chk("rx5a_flags", 32'(n_pe0 - b_pe + n_fe0 - b_fe + n_ov0 - b_ov), 32'(0));
        repeat (50) @(negedge clk);
        chk("rx5a_hold", 32'(rx_valid0), 32'(1));
        consume0();
        chk("rx5a_consumed", 32'(rx_valid0), 32'(0));

        // 8N1 transmit of 0xA5
        tx_frame0(8'hA5, "txa5");

        // False start: 100 clk low pulse
        snap0();
        rx0 = 1'b0;
        repeat (100) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * B0) @(negedge clk);
        chk("false_start_valid", 32'(rx_valid0), 32'(0));
        chk("false_start_flags", 32'(n_pe0 - b_pe + n_fe0 - b_fe + n_ov0 - b_ov), 32'(0));

        // Stop bit low on 0x3C -> frame error, data still delivered
        snap0();
        drive_rx(0, 16'({1'b0, 8'h3C, 1'b0}), 10, B0);
        chk("fe3c_valid", 32'(rx_valid0), 32'(1));
        chk("fe3c_data", 32'(rx_data0), 32'h3C);
        chk("fe3c_fe", 32'(n_fe0 - b_fe), 32'(1));
        consume0();

        // Break: line held low for 15 bit periods -> single frame error
        snap0();
        rx0 = 1'b0;
        repeat (15 * B0) @(negedge clk);
        chk("break_fe_once", 32'(n_fe0 - b_fe), 32'(1));
        chk("break_valid", 32'(rx_valid0), 32'(1));
        chk("break_data", 32'(rx_data0), 32'(0));
        rx0 = 1'b1;
        consume0();
        repeat (B0) @(negedge clk);

        // Overrun: two frames without consuming
        snap0();
        drive_rx(0, 16'({1'b1, 8'h11, 1'b0}), 10, B0);
        chk("ovr_first_data", 32'(rx_data0), 32'h11);
        chk("ovr_first_none", 32'(n_ov0 - b_ov), 32'(0));
        drive_rx(0, 16'({1'b1, 8'h22, 1'b0}), 10, B0);
        chk("ovr_pulse", 32'(n_ov0 - b_ov), 32'(1));
        chk("ovr_data_kept", 32'(rx_data0), 32'h11);
        chk("ovr_valid", 32'(rx_valid0), 32'(1));
        consume0();
        chk("ovr_consumed", 32'(rx_valid0), 32'(0));

        // Asynchronous reset in the middle of a TX frame
        tx_data0  = 8'h00;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        repeat (1000) @(negedge clk);
        chk("mid_frame_tx_low", 32'(tx0), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx0), 32'(1));
        chk("async_rst_ready", 32'(tx_ready0), 32'(1));
        chk("async_rst_busy", 32'(tx_busy0), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tx_frame0(8'h3C, "tx3c");

        // 7E1 instance: 0x35 has four ones, so the even parity bit is 0
        snap1();
        drive_rx(1, 16'({1'b1, 1'b1, 7'h35, 1'b0}), 10, B1);
        chk("par_bad_valid", 32'(rx_valid1), 32'(1));
        chk("par_bad_data", 32'(rx_data1), 32'h35);
        chk("par_bad_pulse", 32'(n_pe1 - b_pe), 32'(1));
        consume1();
        snap1();
        drive_rx(1, 16'({1'b1, 1'b0, 7'h35, 1'b0}), 10, B1);
        chk("par_ok_data", 32'(rx_data1), 32'h35);
        chk("par_ok_pulse", 32'(n_pe1 - b_pe), 32'(0));
        consume1();

        // Loopback tx->rx of every 7-bit value
        loop1 = 1'b1;
        repeat (20) @(negedge clk);
        snap1();
        for (int v = 0; v < 128; v++) begin
            k = 0;
            while (!tx_ready1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            tx_data1  = v[6:0];
            tx_valid1 = 1'b1;
            @(negedge clk);
            tx_valid1 = 1'b0;
            k = 0;
            while (!rx_valid1 && k < 400) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("loop_%02h", v), 32'({rx_valid1, rx_data1}), 32'({1'b1, v[6:0]}));
            consume1();
        end
        chk("loop_flags", 32'(n_pe1 - b_pe + n_fe1 - b_fe + n_ov1 - b_ov), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
